// File: rtl/cordic_log_pkg.sv
// rtl/cordic_log_pkg.sv - shared constants and types for the CORDIC natural-log datapath
//
// Purpose: fixed-point format constants and the range-reduction FSM state type.
// Also used by the CORDIC log core.
package cordic_log_pkg;

  localparam int WIDTH = 32;        // data word width, signed two's complement
  localparam int FRAC  = 24;        // fractional bits of the Q8.24 format
  localparam int ONE_Q = 16777216;  // 1.0 in Q8.24
  localparam int LN2_Q = 11629080;  // ln2 in Q8.24, round-to-nearest
  localparam int EXP_W = 6;         // signed exponent width, covers -24..+6

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OUT
  } state_e;

endpackage

// File: rtl/log_range_reduce_if.sv
// rtl/log_range_reduce_if.sv - argument/result handshake bundle for log_range_reduce
//
// Purpose: groups the input (in_valid/in_ready/arg) and output
// (out_valid/out_ready/mant/exp/offset/err) handshakes.
// Modports: master = producer of arg / consumer of result, slave = the reducer.
interface log_range_reduce_if;
  import cordic_log_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] arg;
  logic                    out_valid;
  logic                    out_ready;
  logic        [WIDTH-1:0] mant;
  logic signed [EXP_W-1:0] exp;
  logic signed [WIDTH-1:0] offset;
  logic                    err;

  modport master (
    output in_valid, arg, out_ready,
    input  in_ready, out_valid, mant, exp, offset, err
  );

  modport slave (
    input  in_valid, arg, out_ready,
    output in_ready, out_valid, mant, exp, offset, err
  );

endinterface

// File: rtl/lzd_norm.sv
// rtl/lzd_norm.sv - leading-one detector plus barrel shift for single-cycle normalisation
//
// Purpose: normalises a positive Q8.24 value to [1.0, 2.0) in one step.
// Ports: m_i (positive value), mant_o (normalised mantissa), exp_o (signed e, m_i = mant_o * 2^e).
// Only built when LOG_RR_FAST_NORM_EN is defined.
`ifdef LOG_RR_FAST_NORM_EN
module lzd_norm
  import cordic_log_pkg::*;
(
  input  logic        [WIDTH-1:0] m_i,
  output logic        [WIDTH-1:0] mant_o,
  output logic signed [EXP_W-1:0] exp_o
);

  int lead;

  always_comb begin
    lead = 0;
    // Ascending scan: the last set bit seen is the most significant one.
    for (int i = 0; i < WIDTH; i++) begin
      if (m_i[i]) lead = i;
    end
    exp_o = EXP_W'(lead - FRAC);
    // A right shift truncates exactly as the iterative one-bit shifts would.
    if (lead >= FRAC) mant_o = m_i >> (lead - FRAC);
    else              mant_o = m_i << (FRAC - lead);
  end

endmodule
`endif

// File: rtl/log_range_reduce.sv
// rtl/log_range_reduce.sv - normalises a positive Q8.24 argument to [1.0, 2.0) for the CORDIC log core
//
// Purpose: arg = mant * 2^exp, offset = exp * ln2, so ln(arg) = ln(mant) + offset.
// Ports: clk, reset (sync, active-high), bus (log_range_reduce_if.slave).
// Option: LOG_RR_FAST_NORM_EN selects single-cycle normalisation via lzd_norm;
// undefined gives one shift per clock.
module log_range_reduce
  import cordic_log_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  log_range_reduce_if.slave     bus
);

  state_e                  state_q, state_d;
  logic        [WIDTH-1:0] m_q, m_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic signed [WIDTH-1:0] off_q, off_d;
  logic                    err_q, err_d;

  // Gated with reset so in_ready is low throughout reset, even before the first edge.
  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = (state_q == OUT);
  assign bus.mant      = m_q;
  assign bus.exp       = exp_q;
  assign bus.offset    = off_q;
  assign bus.err       = err_q;

`ifdef LOG_RR_FAST_NORM_EN
  logic        [WIDTH-1:0] norm_mant;
  logic signed [EXP_W-1:0] norm_exp;

  lzd_norm u_lzd_norm (
    .m_i    (m_q),
    .mant_o (norm_mant),
    .exp_o  (norm_exp)
  );
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    exp_d   = exp_q;
    off_d   = off_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          exp_d = '0;
          off_d = '0;
          if (bus.arg <= 0) begin
            err_d   = 1'b1;
            m_d     = '0;
            state_d = OUT;
          end else begin
            err_d   = 1'b0;
            m_d     = bus.arg;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
`ifdef LOG_RR_FAST_NORM_EN
        m_d     = norm_mant;
        exp_d   = norm_exp;
        off_d   = WIDTH'(int'(norm_exp) * LN2_Q);
        state_d = OUT;
`else
        // Any integer bit above the units bit means m >= 2.0.
        if (m_q[WIDTH-2:FRAC+1] != '0) begin
          m_d   = m_q >> 1;
          exp_d = exp_q + EXP_W'(1);
          off_d = off_q + WIDTH'(LN2_Q);
        end else if (!m_q[FRAC]) begin
          m_d   = m_q << 1;
          exp_d = exp_q - EXP_W'(1);
          off_d = off_q - WIDTH'(LN2_Q);
        end else begin
          state_d = OUT;
        end
`endif
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      exp_q   <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      exp_q   <= exp_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_log_range_reduce.sv
// tb/tb_log_range_reduce.sv - directed self-checking bench for log_range_reduce
module tb_log_range_reduce;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  log_range_reduce_if bus ();

  log_range_reduce dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one argument, measure accept-to-out_valid latency, check result, then drain.
  task automatic run_op(input string tag, input int arg, input int lat_exp,
                        input longint m_exp, input longint e_exp,
                        input longint off_exp, input longint err_exp);
    int lat;
    int wait_cyc;
    wait_cyc = 0;
    while (!bus.in_ready && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    bus.arg      = arg;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_mant"}, longint'(bus.mant), m_exp);
    check({tag, "_exp"}, longint'(bus.exp), e_exp);
    check({tag, "_offset"}, longint'(bus.offset), off_exp);
    check({tag, "_err"}, longint'(bus.err), err_exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ready_after"}, longint'(bus.in_ready), 1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.arg       = '0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    check("rst_in_ready", longint'(bus.in_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_mant", longint'(bus.mant), 0);
    check("rst_exp", longint'(bus.exp), 0);
    check("rst_offset", longint'(bus.offset), 0);
    check("rst_err", longint'(bus.err), 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", longint'(bus.in_ready), 1);

    run_op("one",   16777216,  2, 16777216,  0,          0, 0);
    run_op("six",   100663296, 4, 25165824,  2,   23258160, 0);
    run_op("three", 50331648,  3, 25165824,  1,   11629080, 0);
    run_op("tiny",  1,        26, 16777216, -24, -279097920, 0);
    run_op("max",   32'h7FFF_FFFF, 8, 33554431, 6, 69774480, 0);
    run_op("zero",  0,         1, 0, 0, 0, 1);
    run_op("neg",   -5,        1, 0, 0, 0, 1);
    run_op("after_err", 16777216, 2, 16777216, 0, 0, 0);

    // Back-pressure: result held with out_ready low for 5 cycles.
    bus.arg      = 4194304;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    begin
      int lat;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
        tick();
        lat++;
      end
      check("bp_latency", lat, 4);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", longint'(bus.out_valid), 1);
      check("bp_mant", longint'(bus.mant), 16777216);
      check("bp_exp", longint'(bus.exp), -2);
      check("bp_offset", longint'(bus.offset), -23258160);
      check("bp_err", longint'(bus.err), 0);
      check("bp_in_ready", longint'(bus.in_ready), 0);
      bus.in_valid = 1'b1;  // must be ignored outside IDLE
      bus.arg      = 100663296;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_ready_after", longint'(bus.in_ready), 1);
    check("bp_valid_after", longint'(bus.out_valid), 0);

    // Reset mid-SHIFT on arg=1 aborts the operation.
    bus.arg      = 1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy", longint'(bus.in_ready), 0);
    reset = 1'b1;
    tick();
    check("abort_valid", longint'(bus.out_valid), 0);
    check("abort_ready_in_reset", longint'(bus.in_ready), 0);
    reset = 1'b0;
    #1;
    check("abort_idle", longint'(bus.in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", longint'(bus.out_valid), 0);
    end
    run_op("post_abort", 16777216, 2, 16777216, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/log_range_reduce.md
Name: log_range_reduce

Overview:
Upstream front end for the CORDIC natural-log core. It takes an arbitrary positive Q8.24 argument and normalises it to a mantissa m in [1.0, 2.0), so the core sees an argument inside its convergence range. It also produces the additive offset e*ln2 in Q8.24, so that ln(arg) = ln(m) + offset. Normalisation is iterative, one shift per clock, behind a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, data word width (signed two's complement)
FRAC, 24, fractional bits; 1.0 = 2^FRAC = 16777216
LN2_Q, 11629080, ln2 in Q8.24 (round-to-nearest)
EXP_W, 6, signed exponent width; covers e = -24..+6

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  arg valid
in_ready  out  1  block idle, can accept
arg  in  WIDTH  signed Q8.24 argument
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
mant  out  WIDTH  normalised mantissa, Q8.24, in [1.0, 2.0)
exp  out  EXP_W  signed exponent e, where arg = mant * 2^e
offset  out  WIDTH  signed e*LN2_Q, Q8.24
err  out  1  arg was <= 0; mant/exp/offset are 0

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- Reset values: state = IDLE; in_ready = 0 while reset is high; out_valid, err, mant, exp, offset all 0.
- in_ready = (state == IDLE). It is 1 on the first cycle after reset deasserts.
- States: IDLE, SHIFT, OUT.
- IDLE: on in_valid && in_ready:
  - arg <= 0: set err = 1; clear mant, exp and offset; go to OUT.
  - otherwise: load m_reg = arg; clear exp_reg and off_reg; clear err; go to SHIFT.
- SHIFT, one action per cycle:
  - m_reg[WIDTH-2:FRAC+1] != 0 (m >= 2.0): m_reg >>= 1, exp_reg += 1, off_reg += LN2_Q.
  - else if m_reg[FRAC] == 0 (m < 1.0): m_reg <<= 1, exp_reg -= 1, off_reg -= LN2_Q.
  - else (normalised): go to OUT.
- OUT: out_valid = 1 and outputs are held stable. On out_ready, go to IDLE the next cycle.
- Latency from the accept edge to out_valid:
  - |e| + 2 cycles for a valid arg.
  - 1 cycle for an error.
  - Worst case 26 cycles (arg = 1, e = -24).
- Right shifts truncate; low bits are lost, which is intended. Left shifts are exact.
- Offset arithmetic is exact. The range -279097920..+69774480 fits in WIDTH bits.
- Back-pressure: while out_ready is low in OUT, every output stays constant and in_ready stays 0.
- in_valid is ignored outside IDLE. There is no skid buffer; throughput is one result per (latency + 1) cycles minimum.
- Reset during SHIFT or OUT aborts the operation: the result is discarded, out_valid drops on the reset edge, and the FSM returns to IDLE.
- The block never calls $finish and never reports an error via $display; the err flag is the only error path.

Optional Feature:
LOG_RR_FAST_NORM_EN:
- Defined: SHIFT is replaced by a single-cycle leading-one detector plus barrel shifter, and offset = e*LN2_Q via a constant multiply. Latency is fixed at 2 cycles (1 for error). Output values are bit-identical to the iterative mode.
- Undefined: the iterative per-bit shifting described above is used.

Decomposition:
- Package cordic_log_pkg holds:
  - constants WIDTH, FRAC, ONE_Q = 16777216, LN2_Q, EXP_W;
  - the state enum typedef {IDLE, SHIFT, OUT}.
  - The CORDIC log core shares the same package.
- Sub-module lzd_norm (leading-one detect plus shift amount) is instantiated only under LOG_RR_FAST_NORM_EN.

Test Plan:
- arg=16777216 (1.0) -> mant=16777216, exp=0, offset=0, err=0, out_valid 2 cycles after accept.
- arg=100663296 (6.0) -> mant=25165824 (1.5), exp=2, offset=23258160, latency 4.
- arg=1 -> mant=16777216, exp=-24, offset=-279097920, latency 26.
- arg=0x7FFFFFFF -> mant=33554431, exp=6, offset=69774480. Separately, arg=0 and arg=-5 -> err=1, mant=exp=offset=0, latency 1.
- arg=4194304 (0.25) with out_ready held low 5 cycles after out_valid -> mant=16777216, exp=-2, offset=-23258160, all stable, in_ready=0 throughout; in_ready=1 one cycle after the out_ready pulse.
- Reset asserted mid-SHIFT on arg=1 -> out_valid stays 0, IDLE next cycle; a following arg=16777216 completes normally.
